// File: rtl/pixel_frame_packer.sv
// Packs NCH serial frame lines into FRAME_WIDTH-bit frames and drains each frame as a header plus payload words.
// Latency: the header word is valid the cycle after a frame's last bit; each following word needs one accepted write.
// Backpressure: fifo_full stalls the drain with data_out held; a frame that completes while the drain is busy is dropped.
module pixel_frame_packer #(
    parameter int NCH         = 8,
    parameter int FRAME_WIDTH = 48,
    parameter int NDATA       = 1,
    parameter int FIFO_WIDTH  = 36
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [NCH-1:0]        fd,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  overflow
);
    localparam int FW      = FRAME_WIDTH;
    localparam int PW      = FIFO_WIDTH - 4;
    localparam int FBITS   = NCH * FW;
    localparam int NW      = (FBITS + PW - 1) / PW;
    localparam int HBITS   = NW * PW;
    localparam int NFRAMES = 2 ** NDATA;
    localparam int BW      = $clog2(FW);
    localparam int WW      = (NW > 1) ? $clog2(NW) : 1;
    localparam int NFW     = NDATA + 1;

    localparam logic [3:0] TAG_HDR  = 4'hA;
    localparam logic [3:0] TAG_DAT  = 4'h5;
    localparam logic [3:0] TAG_LAST = 4'h6;

    typedef enum logic {C_IDLE, C_CAP} cap_state_t;
    typedef enum logic [1:0] {D_IDLE, D_HDR, D_DATA} drn_state_t;

    cap_state_t       cap;
    drn_state_t       drn;
    logic             mode_q;
    logic [BW-1:0]    bit_cnt;
    logic [NFW-1:0]   frame_num;
    logic [15:0]      frame_cnt;
    logic [FBITS-1:0] frame;
    logic [FBITS-1:0] frame_next;
    logic [HBITS-1:0] hold;
    logic [HBITS-1:0] hold_next;
    logic [WW-1:0]    word_idx;
    logic             word_vld;
    logic             frame_done;

    // Each channel shifts left so its first sampled bit ends up at the channel MSB.
    always_comb begin
        frame_next = frame;
        for (int c = 0; c < NCH; c++)
            frame_next[c*FW +: FW] = {frame[c*FW +: FW-1], fd[c]};
        hold_next = '0;
        hold_next[HBITS-1 -: FBITS] = frame_next;
    end

    assign frame_done = (cap == C_CAP) && (bit_cnt == BW'(FW - 1));
    assign fifo_wr_en = word_vld & ~fifo_full;
    assign busy       = (cap != C_IDLE) | (drn != D_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cap       <= C_IDLE;
            drn       <= D_IDLE;
            mode_q    <= 1'b0;
            bit_cnt   <= '0;
            frame_num <= '0;
            frame_cnt <= '0;
            frame     <= '0;
            hold      <= '0;
            word_idx  <= '0;
            word_vld  <= 1'b0;
            data_out  <= '0;
            overflow  <= 1'b0;
        end else begin
            case (cap)
                C_IDLE: begin
                    if (start) begin
                        cap       <= C_CAP;
                        mode_q    <= mode;
                        overflow  <= 1'b0;
                        frame_cnt <= '0;
                        bit_cnt   <= '0;
                        frame_num <= '0;
                    end
                end
                default: begin
                    frame   <= frame_next;
                    bit_cnt <= frame_done ? '0 : bit_cnt + 1'b1;
                    if (frame_done) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        frame_num <= frame_num + 1'b1;
                        if (drn != D_IDLE)
                            overflow <= 1'b1;
                        if (!mode_q && frame_num == NFW'(NFRAMES - 1))
                            cap <= C_IDLE;
                    end
                    // A frame finishing on the stop edge is still delivered.
                    if (stop)
                        cap <= C_IDLE;
                end
            endcase

            case (drn)
                D_IDLE: begin
                    if (frame_done) begin
                        hold     <= hold_next;
                        data_out <= {TAG_HDR, PW'(frame_cnt)};
                        word_vld <= 1'b1;
                        drn      <= D_HDR;
                    end
                end
                D_HDR: begin
                    if (fifo_wr_en) begin
                        data_out <= {(NW == 1) ? TAG_LAST : TAG_DAT, hold[HBITS-1 -: PW]};
                        hold     <= hold << PW;
                        word_idx <= '0;
                        drn      <= D_DATA;
                    end
                end
                D_DATA: begin
                    if (fifo_wr_en) begin
                        if (word_idx == WW'(NW - 1)) begin
                            word_vld <= 1'b0;
                            drn      <= D_IDLE;
                        end else begin
                            data_out <= {(word_idx == WW'(NW - 2)) ? TAG_LAST : TAG_DAT,
                                         hold[HBITS-1 -: PW]};
                            hold     <= hold << PW;
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    word_vld <= 1'b0;
                    drn      <= D_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_frame_packer.sv
// Randomized bench: a frame-level reference model queues expected FIFO words; a negedge monitor checks every cycle.
module tb_pixel_frame_packer;
    localparam int NCH     = 8;
    localparam int FW      = 48;
    localparam int NDATA   = 1;
    localparam int FWID    = 36;
    localparam int PW      = FWID - 4;
    localparam int FBITS   = NCH * FW;
    localparam int NW      = (FBITS + PW - 1) / PW;
    localparam int NFRAMES = 2 ** NDATA;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            mode = 1'b0;
    logic [NCH-1:0]  fd = '0;
    logic            fifo_full = 1'b0;
    logic            fifo_wr_en;
    logic [FWID-1:0] data_out;
    logic            busy;
    logic            overflow;

    int checks = 0;
    int errors = 0;

    pixel_frame_packer #(.NCH(NCH), .FRAME_WIDTH(FW), .NDATA(NDATA), .FIFO_WIDTH(FWID)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .fd(fd),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .data_out(data_out),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model + scoreboard ----------------
    logic [FWID-1:0]  exp_q[$];
    bit               m_active = 0;
    bit               m_mode = 0;
    bit               m_ov = 0;
    bit               m_after_rst = 0;
    int               m_bits = 0;
    int               m_frames = 0;
    logic [15:0]      m_cnt = '0;
    logic [FBITS-1:0] m_frame = '0;

    task automatic check(input string name, input logic [FWID-1:0] act, input logic [FWID-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic queue_frame();
        logic [NW*PW-1:0] padv;
        padv = '0;
        padv[NW*PW-1 -: FBITS] = m_frame;
        exp_q.push_back({4'hA, PW'(m_cnt)});
        for (int k = 0; k < NW; k++)
            exp_q.push_back({(k == NW - 1) ? 4'h6 : 4'h5, padv[NW*PW-1-k*PW -: PW]});
    endtask

    always @(negedge clk) begin
        bit exp_wr;
        bit drain_idle;
        exp_wr = (exp_q.size() > 0) && !fifo_full;
        check("busy", FWID'(busy), FWID'(m_active || exp_q.size() > 0));
        check("overflow", FWID'(overflow), FWID'(m_ov));
        check("wr_en", FWID'(fifo_wr_en), FWID'(exp_wr));
        if (exp_q.size() > 0)
            check("data_out", data_out, exp_q[0]);
        if (m_after_rst)
            check("data_out_reset", data_out, '0);

        if (rst) begin
            exp_q.delete();
            m_active = 0; m_ov = 0; m_bits = 0; m_frames = 0; m_cnt = '0;
            m_after_rst = 1;
        end else begin
            m_after_rst = 0;
            drain_idle = (exp_q.size() == 0);
            if (exp_wr)
                void'(exp_q.pop_front());
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_mode = mode; m_ov = 0;
                    m_bits = 0; m_frames = 0; m_cnt = '0;
                end
            end else begin
                for (int c = 0; c < NCH; c++)
                    m_frame[c*FW + FW-1 - m_bits] = fd[c];
                m_bits++;
                if (m_bits == FW) begin
                    m_bits = 0;
                    if (drain_idle) queue_frame();
                    else m_ov = 1;
                    m_cnt++;
                    m_frames++;
                    if (!m_mode && m_frames == NFRAMES)
                        m_active = 0;
                end
                if (stop)
                    m_active = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    int fd_sel = 0;     // 0 random, 1 channel c toggles every 2**c cycles, 2 all ones
    bit full_rand = 0;
    int tcount = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            tcount++;
            case (fd_sel)
                0: fd = NCH'($urandom);
                1: for (int c = 0; c < NCH; c++) fd[c] = tcount[c];
                default: fd = '1;
            endcase
            if (full_rand)
                fifo_full = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic pulse_start(input bit md);
        mode = md;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        // single-shot, toggling channels, no backpressure
        fd_sel = 1;
        pulse_start(1'b0);
        tick(130);

        // single-shot, all ones
        fd_sel = 2;
        pulse_start(1'b0);
        tick(130);

        // continuous with a long stall during frame 0 drain: frame 1 dropped
        fd_sel = 0;
        pulse_start(1'b1);
        tick(52);
        fifo_full = 1'b1;
        tick(60);
        fifo_full = 1'b0;
        tick(40);
        pulse_stop();
        tick(40);

        // continuous, stop at bit 20 of the fourth frame
        pulse_start(1'b1);
        tick(3 * FW + 19);
        pulse_stop();
        tick(40);

        // reset mid-drain, then restart from count 0
        pulse_start(1'b0);
        tick(FW + 6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        pulse_start(1'b0);
        tick(130);

        // start while busy is ignored; start+stop together in idle starts
        pulse_start(1'b0);
        tick(10);
        pulse_start(1'b1);
        tick(120);
        start = 1'b1; stop = 1'b1; mode = 1'b0;
        tick(1);
        start = 1'b0; stop = 1'b0;
        tick(130);

        // random modes, random backpressure, random stop points
        full_rand = 1;
        for (int i = 0; i < 6; i++) begin
            pulse_start(1'($urandom));
            tick($urandom_range(40, 220));
            if ($urandom_range(0, 1) == 1)
                pulse_stop();
            tick(30);
            pulse_stop();
            tick(5);
        end
        full_rand = 0;
        fifo_full = 1'b0;

        // bounded wait for the drain to empty
        for (int i = 0; i < 500 && (busy || exp_q.size() > 0); i++)
            tick(1);
        check("final_queue_empty", FWID'(exp_q.size()), '0);
        check("final_busy", FWID'(busy), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
